// File: rtl/uart_pkt_pkg.sv
// uart_pkt_rx shared types: deframer states, sync default,
// and command codes used by the cracker control logic.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    DATA,
    CHK,
    HOLD
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_STOP   = 8'h02;
  localparam logic [7:0] CMD_LOAD   = 8'h07;
  localparam logic [7:0] CMD_STATUS = 8'h10;

endpackage

// File: rtl/uart_pkt_rx_if.sv
// uart_pkt_rx bus: byte strobe in, held packet and
// payload read port out, error pulses out.
interface uart_pkt_rx_if #(
  parameter int ADDR_W = 6
);
  logic              rx_ready;
  logic [7:0]        rx_byte;
  logic              pkt_valid;
  logic [7:0]        pkt_cmd;
  logic [7:0]        pkt_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              pkt_ack;
  logic              err_chk;
  logic              err_len;
  logic              err_ovr;
  logic              err_tmo;

  modport master (
    output rx_ready, rx_byte, rd_addr, pkt_ack,
    input  pkt_valid, pkt_cmd, pkt_len, rd_data,
    input  err_chk, err_len, err_ovr, err_tmo
  );

  modport slave (
    input  rx_ready, rx_byte, rd_addr, pkt_ack,
    output pkt_valid, pkt_cmd, pkt_len, rd_data,
    output err_chk, err_len, err_ovr, err_tmo
  );
endinterface

// File: rtl/pkt_buf_ram.sv
// Payload buffer: simple dual-port RAM, one write port,
// one registered read port (block RAM friendly).
module pkt_buf_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [7:0]        wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [7:0]        rd
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset) rd <= '0;
    else       rd <= mem[ra];
  end
endmodule

// File: rtl/uart_pkt_rx.sv
// Packet deframer: SYNC, CMD, LEN, payload, CHK.
// Optional inter-byte timeout under PKT_TIMEOUT_EN.
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN        = 64,
  parameter int         ADDR_W         = 6,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  uart_pkt_rx_if.slave bus
);
  state_t state, state_n;

  logic [7:0]        cmd_r, len_r, sum;
  logic [7:0]        pkt_cmd, pkt_len;
  logic [ADDR_W-1:0] idx;
  logic              e_chk, e_len, e_ovr, e_tmo;
  logic              q_chk, q_len, q_ovr, q_tmo;
  logic              we, tmo_hit, rx;
  logic [7:0]        b, chk_sum;

  assign rx      = bus.rx_ready;
  assign b       = bus.rx_byte;
  assign chk_sum = sum + b;

`ifdef PKT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          busy;

  assign busy    = state inside {CMD, LEN, DATA, CHK};
  assign tmo_hit = busy && !rx &&
                   cnt == CW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (reset || rx || !busy || tmo_hit) cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    e_chk   = 1'b0;
    e_len   = 1'b0;
    e_ovr   = 1'b0;
    e_tmo   = 1'b0;
    we      = 1'b0;
    if (state == HOLD) begin
      e_ovr = rx;
      if (bus.pkt_ack) state_n = IDLE;
    end else if (rx) begin
      unique case (state)
        IDLE: if (b == SYNC_BYTE) state_n = CMD;
        CMD:  state_n = LEN;
        LEN: begin
          if ({1'b0, b} > 9'(MAX_LEN)) begin
            e_len   = 1'b1;
            state_n = IDLE;
          end else if (b == 8'd0) begin
            state_n = CHK;
          end else begin
            state_n = DATA;
          end
        end
        DATA: begin
          we = 1'b1;
          if (8'(idx) == len_r - 8'd1) state_n = CHK;
        end
        CHK: begin
          if (chk_sum == 8'd0) begin
            state_n = HOLD;
          end else begin
            e_chk   = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (tmo_hit) begin
      e_tmo   = 1'b1;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_r   <= '0;
      len_r   <= '0;
      sum     <= '0;
      idx     <= '0;
      pkt_cmd <= '0;
      pkt_len <= '0;
      q_chk   <= 1'b0;
      q_len   <= 1'b0;
      q_ovr   <= 1'b0;
      q_tmo   <= 1'b0;
    end else begin
      q_chk <= e_chk;
      q_len <= e_len;
      q_ovr <= e_ovr;
      q_tmo <= e_tmo;
      if (rx) begin
        unique case (state)
          CMD: begin
            cmd_r <= b;
            sum   <= b;
          end
          LEN: begin
            len_r <= b;
            idx   <= '0;
            sum   <= chk_sum;
          end
          DATA: begin
            idx <= idx + 1'b1;
            sum <= chk_sum;
          end
          CHK: begin
            if (chk_sum == 8'd0) begin
              pkt_cmd <= cmd_r;
              pkt_len <= len_r;
            end
          end
          default: ;
        endcase
      end
    end
  end

  pkt_buf_ram #(.ADDR_W(ADDR_W)) u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wa    (idx),
    .wd    (b),
    .ra    (bus.rd_addr),
    .rd    (bus.rd_data)
  );

  assign bus.pkt_valid = (state == HOLD);
  assign bus.pkt_cmd   = pkt_cmd;
  assign bus.pkt_len   = pkt_len;
  assign bus.err_chk   = q_chk;
  assign bus.err_len   = q_len;
  assign bus.err_ovr   = q_ovr;
  assign bus.err_tmo   = q_tmo;
endmodule

// File: tb/tb_uart_pkt_rx.sv
// Self-checking bench for uart_pkt_rx: vector table plus
// hand sequences for overrun, reset, max length, timeout.
module tb_uart_pkt_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_pkt_rx_if #(.ADDR_W(6)) bus();

  uart_pkt_rx #(
    .MAX_LEN        (64),
    .ADDR_W         (6),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {K_OK, K_CHK, K_LEN} kind_e;

  typedef struct {
    logic [63:0] bytes;
    int          n;
    kind_e       kind;
    logic [7:0]  cmd, len, d0, d1;
  } vec_t;

  typedef struct {
    kind_e      kind;
    logic [7:0] cmd, len, d0, d1;
  } exp_t;

  vec_t tbl [5];
  exp_t sb [$];
  int checks = 0;
  int errors = 0;
  int n_chk = 0, n_len = 0, n_ovr = 0, n_tmo = 0;

  always @(negedge clk) begin
    n_chk += int'(bus.err_chk);
    n_len += int'(bus.err_len);
    n_ovr += int'(bus.err_ovr);
    n_tmo += int'(bus.err_tmo);
  end

  function automatic vec_t mk(logic [63:0] bytes, int n,
                              kind_e k, logic [7:0] cmd,
                              logic [7:0] len, logic [7:0] d0,
                              logic [7:0] d1);
    vec_t v;
    v.bytes = bytes;
    v.n     = n;
    v.kind  = k;
    v.cmd   = cmd;
    v.len   = len;
    v.d0    = d0;
    v.d1    = d1;
    return v;
  endfunction

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a,
                    output logic [7:0] d);
    bus.rd_addr = a;
    @(negedge clk);
    #1;
    d = bus.rd_data;
  endtask

  task automatic ack();
    bus.pkt_ack = 1'b1;
    @(negedge clk);
    bus.pkt_ack = 1'b0;
    #1;
    chk("valid_after_ack", int'(bus.pkt_valid), 0);
  endtask

  task automatic finish_pkt(input int c0, input int l0,
                            input int o0, input bit do_ack);
    exp_t e;
    bit got;
    logic [7:0] d;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      got = bus.pkt_valid || n_chk != c0 || n_len != l0;
      if (!got) @(negedge clk);
    end
    chk("event_seen", int'(got), 1);
    e = sb.pop_front();
    repeat (2) @(negedge clk);
    #1;
    if (e.kind == K_OK) begin
      chk("pkt_valid", int'(bus.pkt_valid), 1);
      chk("pkt_cmd", int'(bus.pkt_cmd), int'(e.cmd));
      chk("pkt_len", int'(bus.pkt_len), int'(e.len));
      chk("no_err", (n_chk - c0) + (n_len - l0) + (n_ovr - o0), 0);
      if (e.len > 0) begin
        rd(6'd0, d);
        chk("rd_addr0", int'(d), int'(e.d0));
      end
      if (e.len > 1) begin
        rd(6'd1, d);
        chk("rd_addr1", int'(d), int'(e.d1));
      end
      if (do_ack) ack();
    end else begin
      chk("valid_low", int'(bus.pkt_valid), 0);
      chk("err_chk_cnt", n_chk - c0, int'(e.kind == K_CHK));
      chk("err_len_cnt", n_len - l0, int'(e.kind == K_LEN));
      chk("err_ovr_cnt", n_ovr - o0, 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit do_ack);
    exp_t e;
    int c0, l0, o0;
    e.kind = v.kind;
    e.cmd  = v.cmd;
    e.len  = v.len;
    e.d0   = v.d0;
    e.d1   = v.d1;
    sb.push_back(e);
    c0 = n_chk;
    l0 = n_len;
    o0 = n_ovr;
    for (int i = 0; i < v.n; i++)
      send(v.bytes[63 - 8*i -: 8]);
    finish_pkt(c0, l0, o0, do_ack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] d, s;
    int c0, l0, o0, t0, i;

    tbl[0] = mk(64'hA5_01_02_10_20_CD_00_00, 6, K_OK,
                8'h01, 8'h02, 8'h10, 8'h20);
    tbl[1] = mk(64'hA5_07_00_F9_00_00_00_00, 4, K_OK,
                8'h07, 8'h00, 8'h00, 8'h00);
    tbl[2] = mk(64'hA5_01_02_10_20_CE_00_00, 6, K_CHK,
                8'h00, 8'h00, 8'h00, 8'h00);
    tbl[3] = mk(64'hA5_01_41_00_00_00_00_00, 3, K_LEN,
                8'h00, 8'h00, 8'h00, 8'h00);
    tbl[4] = mk(64'h00_FF_A4_A5_03_01_A5_57, 8, K_OK,
                8'h03, 8'h01, 8'hA5, 8'h00);

    bus.rx_ready = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.rd_addr  = '0;
    bus.pkt_ack  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", int'(bus.pkt_valid), 0);
    chk("rst_cmd_len", int'({bus.pkt_cmd, bus.pkt_len}), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_err", int'({bus.err_chk, bus.err_len,
                         bus.err_ovr, bus.err_tmo}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(tbl[k], 1'b1);

    // Held packet: overrun drops bytes, held data untouched
    run_vec(tbl[0], 1'b0);
    o0 = n_ovr;
    send(8'hA5);
    send(8'h00);
    send(8'h11);
    repeat (2) @(negedge clk);
    #1;
    chk("ovr_cnt3", n_ovr - o0, 3);
    chk("hold_valid", int'(bus.pkt_valid), 1);
    chk("hold_cmd_len", int'({bus.pkt_cmd, bus.pkt_len}),
        int'(16'h0102));
    rd(6'd0, d);
    chk("hold_rd0", int'(d), 8'h10);
    rd(6'd1, d);
    chk("hold_rd1", int'(d), 8'h20);
    bus.pkt_ack  = 1'b1;
    bus.rx_byte  = 8'hA5;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.pkt_ack  = 1'b0;
    bus.rx_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("ovr_ack_cycle", n_ovr - o0, 4);
    chk("ack_valid", int'(bus.pkt_valid), 0);
    run_vec(tbl[1], 1'b1);

    // Reset mid-packet
    send(8'hA5);
    send(8'h01);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_valid", int'(bus.pkt_valid), 0);
    chk("midrst_err", int'({bus.err_chk, bus.err_len,
                            bus.err_ovr, bus.err_tmo}), 0);
    reset = 1'b0;
    @(negedge clk);
    run_vec(tbl[0], 1'b1);

    // Maximum length payload
    e.kind = K_OK;
    e.cmd  = 8'h02;
    e.len  = 8'h40;
    e.d0   = 8'h01;
    e.d1   = 8'h04;
    sb.push_back(e);
    c0 = n_chk;
    l0 = n_len;
    o0 = n_ovr;
    s  = 8'h02 + 8'h40;
    send(8'hA5);
    send(8'h02);
    send(8'h40);
    for (int k = 0; k < 64; k++) begin
      d = 8'(k * 3 + 1);
      s = s + d;
      send(d);
    end
    send(8'(0) - s);
    finish_pkt(c0, l0, o0, 1'b0);
    rd(6'd63, d);
    chk("max_rd63", int'(d), 8'hBE);
    ack();

    t0 = n_tmo;
    send(8'hA5);
    send(8'h01);
`ifdef PKT_TIMEOUT_EN
    for (i = 1; i <= 200; i++) begin
      @(negedge clk);
      #1;
      if (bus.err_tmo) break;
    end
    chk("tmo_cycles", i, 100);
    repeat (3) @(negedge clk);
    chk("tmo_single", n_tmo - t0, 1);
    run_vec(tbl[1], 1'b1);
`else
    repeat (150) @(negedge clk);
    chk("no_tmo", n_tmo - t0, 0);
    e.kind = K_OK;
    e.cmd  = 8'h01;
    e.len  = 8'h00;
    e.d0   = 8'h00;
    e.d1   = 8'h00;
    sb.push_back(e);
    c0 = n_chk;
    l0 = n_len;
    o0 = n_ovr;
    send(8'h00);
    send(8'hFF);
    finish_pkt(c0, l0, o0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
